// File: rtl/div_seq_if.sv
// Handshake and operand bundle between the instruction decoder and the
// sequential divider.
interface div_seq_if;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN short-circuits a zero divisor to a 0 result.
module div_seq (
    input  logic     clk,
    input  logic     resetn,
    div_seq_if.slave bus
);
    localparam int DATA_W = 32;

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DIVZERO} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [5:0]            r_cnt;
    logic [2*DATA_W:0]     r_rq;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_dsign;
    logic                  r_qsign;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_accept;
    logic [DATA_W+1:0]     w_sub;
    logic [2*DATA_W:0]     w_rq_step;
    logic [2*DATA_W-1:0]   w_res_fix;

    // Two's-complement negate when requested; used both for magnitudes and sign fix-up.
    function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] v,
                                                     input logic neg);
        logic signed [DATA_W-1:0] s;
        s = signed'(v);
        return neg ? unsigned'(-s) : v;
    endfunction

    assign w_accept = bus.start_i & ~bus.annul_i;

    // Restoring step: the top 34 bits of {rem,quo} are the shifted partial remainder.
    assign w_sub     = r_rq[2*DATA_W:DATA_W-1] - {2'b00, r_divisor};
    assign w_rq_step = w_sub[DATA_W+1] ? {r_rq[2*DATA_W-1:0], 1'b0}
                                       : {w_sub[DATA_W:0], r_rq[DATA_W-2:0], 1'b1};
    assign w_res_fix = {f_cond_neg(w_rq_step[2*DATA_W-1:DATA_W], r_dsign),
                        f_cond_neg(w_rq_step[DATA_W-1:0], r_qsign)};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (bus.annul_i)
                    w_state_nxt = S_IDLE;
`ifdef DIV_ZERO_FAST_EN
                else if (r_divisor == '0)
                    w_state_nxt = S_DIVZERO;
`endif
                else if (r_cnt == 6'd31)
                    w_state_nxt = S_DONE;
            end
`ifdef DIV_ZERO_FAST_EN
            S_DIVZERO: w_state_nxt = bus.annul_i ? S_IDLE : S_DONE;
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rq      <= '0;
            r_divisor <= '0;
            r_dsign   <= 1'b0;
            r_qsign   <= 1'b0;
            r_result  <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_cnt     <= '0;
                r_rq      <= {{(DATA_W+1){1'b0}},
                              f_cond_neg(bus.opdata1_i, bus.signed_i & bus.opdata1_i[DATA_W-1])};
                r_divisor <= f_cond_neg(bus.opdata2_i, bus.signed_i & bus.opdata2_i[DATA_W-1]);
                r_dsign   <= bus.signed_i & bus.opdata1_i[DATA_W-1];
                r_qsign   <= bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            end
            if (r_state == S_BUSY && !bus.annul_i) begin
                r_rq  <= w_rq_step;
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == S_BUSY && w_state_nxt == S_DONE)
                r_result <= w_res_fix;
`ifdef DIV_ZERO_FAST_EN
            if (r_state == S_DIVZERO && w_state_nxt == S_DONE)
                r_result <= '0;
`endif
        end
    end

    always_comb begin
        bus.stall_o = 1'b0;
        case (r_state)
            S_IDLE:    bus.stall_o = w_accept;
            S_BUSY:    bus.stall_o = 1'b1;
`ifdef DIV_ZERO_FAST_EN
            S_DIVZERO: bus.stall_o = 1'b1;
`endif
            default:   bus.stall_o = 1'b0;
        endcase
    end

    assign bus.ready_o  = (r_state == S_DONE);
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; expected values are hand-computed.
// Zero-divisor expectations follow DIV_ZERO_FAST_EN when the build defines it.
module tb_div_seq;
    logic clk;
    logic resetn;
    int   npass;
    int   ntotal;

    div_seq_if u_if ();

    div_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide; start is sampled at the next edge (edge 0).
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int exp_lat, input logic [63:0] exp_res);
        int n;
        int st;
        u_if.opdata1_i = a;
        u_if.opdata2_i = b;
        u_if.signed_i  = s;
        u_if.annul_i   = 1'b0;
        u_if.start_i   = 1'b1;
        #1;
        chk({tag, "_stall_req"}, 64'(u_if.stall_o), 64'd1);
        st = 1;
        tick();
        u_if.start_i   = 1'b0;
        u_if.opdata1_i = 32'hDEAD_BEEF;
        u_if.opdata2_i = 32'h0000_1234;
        u_if.signed_i  = ~s;
        st += int'(u_if.stall_o);
        n = 0;
        while (!u_if.ready_o && n < 40) begin
            tick();
            n++;
            if (!u_if.ready_o) st += int'(u_if.stall_o);
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(st), 64'(exp_lat + 1));
        chk({tag, "_stall_done"}, 64'(u_if.stall_o), 64'd0);
        chk({tag, "_result"}, u_if.result_o, exp_res);
        tick();
        chk({tag, "_ready_pulse"}, 64'(u_if.ready_o), 64'd0);
        chk({tag, "_result_hold"}, u_if.result_o, exp_res);
    endtask

    initial begin
        int nrdy;
        npass  = 0;
        ntotal = 0;
        resetn = 1'b0;
        u_if.start_i   = 1'b0;
        u_if.signed_i  = 1'b0;
        u_if.annul_i   = 1'b0;
        u_if.opdata1_i = '0;
        u_if.opdata2_i = '0;
        #3;
        chk("rst_result", u_if.result_o, 64'h0);
        chk("rst_ready", 64'(u_if.ready_o), 64'd0);
        chk("rst_stall", 64'(u_if.stall_o), 64'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        do_div("u100_7", 32'd100, 32'd7, 1'b0, 32, {32'h0000_0002, 32'h0000_000E});
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("u_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32, {32'h0000_0001, 32'h7FFF_FFFC});
        do_div("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32, {32'h0000_0002, 32'hFFFF_FFF2});
        do_div("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32, {32'hFFFF_FFFE, 32'h0000_000E});
        do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32, {32'h0000_0000, 32'h8000_0000});

        // start together with annul in IDLE must not launch anything
        u_if.opdata1_i = 32'd40;
        u_if.opdata2_i = 32'd4;
        u_if.start_i   = 1'b1;
        u_if.annul_i   = 1'b1;
        #1;
        chk("idle_annul_stall", 64'(u_if.stall_o), 64'd0);
        tick();
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;
        chk("idle_annul_nostart", 64'(u_if.stall_o), 64'd0);

        // annul at BUSY step 10
        u_if.opdata1_i = 32'd50;
        u_if.opdata2_i = 32'd5;
        u_if.signed_i  = 1'b0;
        u_if.start_i   = 1'b1;
        tick();
        u_if.start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        u_if.annul_i = 1'b1;
        #1;
        chk("annul_busy_stall", 64'(u_if.stall_o), 64'd1);
        tick();
        u_if.annul_i = 1'b0;
        chk("annul_idle_stall", 64'(u_if.stall_o), 64'd0);
        chk("annul_no_ready", 64'(u_if.ready_o), 64'd0);
        chk("annul_result_hold", u_if.result_o, {32'h0000_0000, 32'h8000_0000});
        do_div("u9_3", 32'd9, 32'd3, 1'b0, 32, {32'h0000_0000, 32'h0000_0003});

`ifdef DIV_ZERO_FAST_EN
        do_div("u5_0", 32'd5, 32'd0, 1'b0, 2, 64'h0);
`else
        do_div("u5_0", 32'd5, 32'd0, 1'b0, 32, {32'h0000_0005, 32'hFFFF_FFFF});
`endif

        // asynchronous reset at BUSY step 20
        u_if.opdata1_i = 32'd1000;
        u_if.opdata2_i = 32'd10;
        u_if.signed_i  = 1'b0;
        u_if.start_i   = 1'b1;
        tick();
        u_if.start_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        resetn = 1'b0;
        #1;
        chk("busy_rst_result", u_if.result_o, 64'h0);
        chk("busy_rst_stall", 64'(u_if.stall_o), 64'd0);
        chk("busy_rst_ready", 64'(u_if.ready_o), 64'd0);
        tick();
        resetn = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            nrdy += int'(u_if.ready_o);
        end
        chk("post_rst_no_ready", 64'(nrdy), 64'd0);
        do_div("u1000_10", 32'd1000, 32'd10, 1'b0, 32, {32'h0000_0000, 32'h0000_0064});

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; resetn input 1, asynchronous active-low reset.
REQ-002 SHALL have port: start_i  input  1  divide request from decoder startDiv; sampled only in IDLE.
REQ-003 SHALL have port: signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); decoder Sign.
REQ-004 SHALL have port: annul_i  input  1  cancel of the in-flight or requested divide; decoder annul.
REQ-005 SHALL have port: opdata1_i  input  32  dividend (rs).
REQ-006 SHALL have port: opdata2_i  input  32  divisor (rt).
REQ-007 SHALL have port: result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-008 SHALL have port: ready_o  output  1  result valid, one-cycle pulse.
REQ-009 SHALL have port: stall_o  output  1  pipeline stall request while a divide is pending.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE, plus DIVZERO when DIV_ZERO_FAST_EN is defined.
REQ-011 In IDLE, start_i=1 with annul_i=0 SHALL latch opdata1_i, opdata2_i and signed_i, clear the 6-bit iteration counter and enter BUSY.
REQ-012 In IDLE, start_i=1 with annul_i=1 SHALL remain in IDLE with no latch.
REQ-013 Signed mode SHALL convert both operands to magnitudes at latch and record the dividend sign and the quotient sign (dividend[31]^divisor[31]).
REQ-014 BUSY SHALL perform one restoring shift-subtract step per clock on a 65-bit {partial remainder, quotient} register, for exactly 32 steps, then enter DONE.
REQ-015 On entry to DONE: the quotient SHALL be negated if the quotient sign is set; the remainder SHALL take the dividend sign; unsigned mode SHALL apply no correction.
REQ-016 Dividend 0x80000000 by divisor 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000, remainder 0; no trap.
REQ-017 ready_o SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 Latency: ready_o SHALL be high in the cycle after the 32nd rising edge following the start-sampling edge.
REQ-019 stall_o SHALL be combinationally 1 when (IDLE & start_i & ~annul_i) or BUSY or DIVZERO, and SHALL be 0 in DONE and otherwise.
REQ-020 result_o SHALL be registered, updated only on entry to DONE, and SHALL hold its value until the next DONE or reset.
REQ-021 annul_i=1 in BUSY or DIVZERO SHALL force IDLE on the next edge with result_o unchanged and no ready_o pulse.
REQ-022 annul_i SHALL be ignored in DONE.
REQ-023 start_i SHALL be ignored in BUSY, DIVZERO and DONE; a new start is accepted in IDLE only, including the cycle immediately after DONE or annul.
REQ-024 Operand changes after latch SHALL NOT affect the result.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, counter 0, internal operand/sign registers 0, result_o=64'h0, ready_o=0; stall_o SHALL then read 0.
REQ-026 Reset during BUSY SHALL discard the operation with no ready_o pulse after release.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN defined: a latched divisor of 0 SHALL enter DIVZERO for one cycle, then DONE with result_o=64'h0 (ready at the 2nd edge after start).
REQ-028 Macro DIV_ZERO_FAST_EN undefined: divisor 0 SHALL run the full 32 steps, giving unsigned quotient 0xFFFFFFFF and remainder = |dividend| before the REQ-015 sign correction.

Verification
REQ-029 Unsigned 100/7: start at edge 0 -> stall_o high 33 cycles, ready_o pulse after edge 32, result_o = {0x00000002, 0x0000000E}.
REQ-030 Signed 0xFFFFFFF9 (-7) / 0x00000002 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; same operands unsigned -> {0x00000001, 0x7FFFFFFC}.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000}, no ready_o glitch.
REQ-032 annul_i pulsed at BUSY step 10 -> IDLE next edge, no ready_o, result_o holds its prior value; start on the following cycle with 9/3 -> {0, 3}.
REQ-033 Divisor 0, dividend 5: with DIV_ZERO_FAST_EN -> ready_o after edge 2, result 0; without -> ready_o after edge 32, result {0x00000005, 0xFFFFFFFF}.
REQ-034 resetn low at BUSY step 20 -> result_o=0, stall_o=0 immediately; no ready_o after release; the next start completes normally.
